// File: rtl/grid_scan_driver.sv
// grid_scan_driver: double-buffered 8x8 row-scan driver with blanking between rows.
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   grid[63:0]   new generation, bit 8*r+c = row r column c
//   grid_valid   grid holds a new generation
//   grid_ready   pending buffer empty, a grid can be accepted
//   row_sel_n    active-low row enables, at most one low
//   col_out      active-high column drive for the selected row
//   frame_done   one-cycle pulse in the last ON cycle of row 7
//   brightness   3-bit PWM duty, present only when GRID_SCAN_DIM_PWM_EN is defined
// Macro GRID_SCAN_DIM_PWM_EN enables PWM dimming of col_out during ON.
module grid_scan_driver #(
    parameter int ROW_ON_CYCLES = 1000,
    parameter int BLANK_CYCLES  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
`ifdef GRID_SCAN_DIM_PWM_EN
    input  logic [2:0]  brightness,
`endif
    input  logic [63:0] grid,
    input  logic        grid_valid,
    output logic        grid_ready,
    output logic [7:0]  row_sel_n,
    output logic [7:0]  col_out,
    output logic        frame_done
);
    localparam logic [15:0] ON_LAST = 16'(ROW_ON_CYCLES - 1);
    localparam logic [15:0] BL_LAST = 16'(BLANK_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  row_q, row_d;
    logic [63:0] pend_q, pend_d, disp_q, disp_d;
    logic        full_q, full_d;
    logic [7:0]  sel_q, col_q;
    logic        done_q;
    logic        xfer, swap, lit;
    always_comb begin
        xfer    = grid_valid && !full_q;
        swap    = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        row_d   = row_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (full_q) begin
                    state_d = BLANK;
                    row_d   = '0;
                    swap    = 1'b1;
                end
            end
            BLANK: if (cnt_q == BL_LAST) begin
                state_d = ON;
                cnt_d   = '0;
            end
            ON: if (cnt_q == ON_LAST) begin
                state_d = BLANK;
                cnt_d   = '0;
                row_d   = row_q + 3'd1;
                // swap only at the frame boundary so a frame never mixes generations
                swap    = (row_q == 3'd7) && full_q;
            end
            default: state_d = IDLE;
        endcase
        // xfer needs an empty buffer and swap a full one, so they never coincide
        pend_d = xfer ? grid : pend_q;
        full_d = xfer || (full_q && !swap);
        disp_d = swap ? pend_q : disp_q;
`ifdef GRID_SCAN_DIM_PWM_EN
        lit    = (state_d == ON) && (cnt_d[2:0] <= brightness);
`else
        lit    = (state_d == ON);
`endif
    end
    // outputs are registered from next-state so they line up with the state they describe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            pend_q  <= '0;
            disp_q  <= '0;
            full_q  <= 1'b0;
            sel_q   <= 8'hFF;
            col_q   <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            pend_q  <= pend_d;
            disp_q  <= disp_d;
            full_q  <= full_d;
            sel_q   <= (state_d == ON) ? ~(8'd1 << row_d) : 8'hFF;
            col_q   <= lit ? disp_d[{row_d, 3'b000} +: 8] : 8'h00;
            done_q  <= (state_d == ON) && (row_d == 3'd7) && (cnt_d == ON_LAST);
        end
    end
    assign grid_ready = !full_q;
    assign row_sel_n  = sel_q;
    assign col_out    = col_q;
    assign frame_done = done_q;
endmodule

// File: tb/tb_grid_scan_driver.sv
// tb_grid_scan_driver: directed self-checking bench for grid_scan_driver (ON=4, BLANK=2).
module tb_grid_scan_driver;
    localparam int ON = 4;
    localparam int BL = 2;
    localparam int RP = ON + BL;
    localparam int FP = 8 * RP;
    localparam logic [63:0] DIAG = 64'h8040_2010_0804_0201;
    localparam logic [63:0] ANTI = 64'h0102_0408_1020_4080;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] grid = '0;
    logic        grid_valid = 1'b0;
    logic        grid_ready;
    logic [7:0]  row_sel_n, col_out;
    logic        frame_done;
    logic [2:0]  brightness = 3'd7;
    int tests = 0;
    int fails = 0;
    always #5 clk = ~clk;
    grid_scan_driver #(.ROW_ON_CYCLES(ON), .BLANK_CYCLES(BL)) dut (
        .clk(clk),
        .reset_n(reset_n),
`ifdef GRID_SCAN_DIM_PWM_EN
        .brightness(brightness),
`endif
        .grid(grid),
        .grid_valid(grid_valid),
        .grid_ready(grid_ready),
        .row_sel_n(row_sel_n),
        .col_out(col_out),
        .frame_done(frame_done)
    );
    // t counts rising edges after the accepting edge; row r is ON for t in [3+6r, 6+6r] of each frame
    function automatic logic [7:0] e_sel(int t);
        int p = (t - 1) % RP;
        int r = ((t - 1) / RP) % 8;
        return (p < BL) ? 8'hFF : ~(8'd1 << r);
    endfunction
    function automatic logic [7:0] e_col(int t, logic [63:0] g);
        int p = (t - 1) % RP;
        int r = ((t - 1) / RP) % 8;
        return (p < BL) ? 8'h00 : g[8*r +: 8];
    endfunction
    task automatic start(input logic [63:0] g);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        grid = g;
        grid_valid = 1'b1;
        @(negedge clk);
        grid_valid = 1'b0;
    endtask
    task automatic test_reset;
        repeat (2) @(negedge clk);
        tests++; if (row_sel_n !== 8'hFF) begin fails++; $display("FAIL rst_sel got %h exp ff", row_sel_n); end
        tests++; if (col_out !== 8'h00) begin fails++; $display("FAIL rst_col got %h exp 00", col_out); end
        tests++; if (grid_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got %b exp 1", grid_ready); end
        tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL rst_done got %b exp 0", frame_done); end
    endtask
    task automatic test_single;
        start(64'h0000_0000_0000_00FF);
        tests++; if (grid_ready !== 1'b0) begin fails++; $display("FAIL single_ready0 got %b exp 0", grid_ready); end
        tests++; if (row_sel_n !== 8'hFF) begin fails++; $display("FAIL single_idle_sel got %h exp ff", row_sel_n); end
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            tests++; if (row_sel_n !== e_sel(t)) begin fails++; $display("FAIL single_sel t=%0d got %h exp %h", t, row_sel_n, e_sel(t)); end
            tests++; if (col_out !== e_col(t, 64'hFF)) begin fails++; $display("FAIL single_col t=%0d got %h exp %h", t, col_out, e_col(t, 64'hFF)); end
            tests++; if (grid_ready !== 1'b1) begin fails++; $display("FAIL single_ready t=%0d got %b exp 1", t, grid_ready); end
        end
    endtask
    task automatic test_diag;
        start(DIAG);
        for (int t = 1; t <= 2 * FP; t++) begin
            @(negedge clk);
            tests++; if (row_sel_n !== e_sel(t)) begin fails++; $display("FAIL diag_sel t=%0d got %h exp %h", t, row_sel_n, e_sel(t)); end
            tests++; if (col_out !== e_col(t, DIAG)) begin fails++; $display("FAIL diag_col t=%0d got %h exp %h", t, col_out, e_col(t, DIAG)); end
            tests++; if (frame_done !== (t % FP == 0)) begin fails++; $display("FAIL diag_done t=%0d got %b exp %b", t, frame_done, t % FP == 0); end
        end
    endtask
    task automatic test_midframe;
        start(DIAG);
        for (int t = 1; t <= 2 * FP; t++) begin
            @(negedge clk);
            grid_valid = 1'b0;
            tests++; if (grid_ready !== !(t >= 21 && t <= FP)) begin fails++; $display("FAIL mid_ready t=%0d got %b exp %b", t, grid_ready, !(t >= 21 && t <= FP)); end
            tests++; if (col_out !== e_col(t, t <= FP ? DIAG : ANTI)) begin fails++; $display("FAIL mid_col t=%0d got %h exp %h", t, col_out, e_col(t, t <= FP ? DIAG : ANTI)); end
            tests++; if (row_sel_n !== e_sel(t)) begin fails++; $display("FAIL mid_sel t=%0d got %h exp %h", t, row_sel_n, e_sel(t)); end
            if (t == 20) begin
                grid = ANTI;
                grid_valid = 1'b1;
            end
        end
    endtask
    task automatic test_boundary;
        start(DIAG);
        for (int t = 1; t <= 3 * FP; t++) begin
            @(negedge clk);
            grid_valid = 1'b0;
            tests++; if (grid_ready !== !(t > FP && t <= 2 * FP)) begin fails++; $display("FAIL bnd_ready t=%0d got %b exp %b", t, grid_ready, !(t > FP && t <= 2 * FP)); end
            tests++; if (col_out !== e_col(t, t <= 2 * FP ? DIAG : ANTI)) begin fails++; $display("FAIL bnd_col t=%0d got %h exp %h", t, col_out, e_col(t, t <= 2 * FP ? DIAG : ANTI)); end
            if (t == FP) begin
                grid = ANTI;
                grid_valid = 1'b1;
            end
        end
    endtask
    task automatic test_reset_mid;
        start(DIAG);
        for (int t = 1; t <= 22; t++) begin
            @(negedge clk);
            grid_valid = 1'b0;
            if (t == 10) begin
                grid = ANTI;
                grid_valid = 1'b1;
            end
        end
        tests++; if (grid_ready !== 1'b0) begin fails++; $display("FAIL rmid_pend got %b exp 0", grid_ready); end
        tests++; if (row_sel_n !== 8'hF7) begin fails++; $display("FAIL rmid_row3 got %h exp f7", row_sel_n); end
        #2 reset_n = 1'b0;
        #1;
        tests++; if (row_sel_n !== 8'hFF) begin fails++; $display("FAIL rmid_sel got %h exp ff", row_sel_n); end
        tests++; if (col_out !== 8'h00) begin fails++; $display("FAIL rmid_col got %h exp 00", col_out); end
        tests++; if (grid_ready !== 1'b1) begin fails++; $display("FAIL rmid_ready got %b exp 1", grid_ready); end
        tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL rmid_done got %b exp 0", frame_done); end
        @(negedge clk);
        reset_n = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            tests++; if (row_sel_n !== 8'hFF || col_out !== 8'h00 || grid_ready !== 1'b1) begin
                fails++; $display("FAIL rmid_idle t=%0d got sel=%h col=%h rdy=%b exp ff 00 1", t, row_sel_n, col_out, grid_ready);
            end
        end
    endtask
`ifdef GRID_SCAN_DIM_PWM_EN
    task automatic test_pwm;
        logic [7:0] e;
        brightness = 3'd1;
        start(64'hFFFF_FFFF_FFFF_FFFF);
        for (int t = 1; t <= FP; t++) begin
            @(negedge clk);
            e = ((t - 1) % RP < BL) ? 8'h00 : (((t - 1) % RP - BL) <= 1 ? 8'hFF : 8'h00);
            tests++; if (col_out !== e) begin fails++; $display("FAIL pwm_col t=%0d got %h exp %h", t, col_out, e); end
            tests++; if (row_sel_n !== e_sel(t)) begin fails++; $display("FAIL pwm_sel t=%0d got %h exp %h", t, row_sel_n, e_sel(t)); end
        end
        brightness = 3'd7;
    endtask
`endif
    initial begin
        test_reset;
        test_single;
        test_diag;
        test_midframe;
        test_boundary;
        test_reset_mid;
`ifdef GRID_SCAN_DIM_PWM_EN
        test_pwm;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/grid_scan_driver.md
GRID_SCAN_DRIVER -- requirements
Module: grid_scan_driver

Interface
REQ-001 Parameter ROW_ON_CYCLES, default 1000, SHALL set the clock cycles each row is driven; legal range 8..65535.
REQ-002 Parameter BLANK_CYCLES, default 16, SHALL set the all-rows-off cycles before each row; legal range 1..255.
REQ-003 clk  in  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 grid  in  64  SHALL carry the game grid; bit 8*r+c is row r, column c; 1 = live.
REQ-006 grid_valid  in  1  SHALL indicate that grid holds a new generation.
REQ-007 grid_ready  out  1  SHALL indicate that the pending buffer is empty and can accept a grid.
REQ-008 row_sel_n  out  8  SHALL be the active-low row enables, with at most one bit low.
REQ-009 col_out  out  8  SHALL be the active-high column drive for the selected row.
REQ-010 frame_done  out  1  SHALL be a one-cycle pulse marking the end of each displayed frame.

Function
REQ-011 A transfer SHALL occur on any cycle with grid_valid=1 and grid_ready=1; grid is then captured into the pending buffer and grid_ready goes 0 on the next cycle.
REQ-012 The block SHALL keep two 64-bit registers: pending (written by a transfer) and display (the source of col_out).
REQ-013 States SHALL be IDLE, BLANK and ON.
- IDLE: outputs off.
- BLANK: row_sel_n=8'hFF, col_out=0.
- ON: row_sel_n bit row_idx low, col_out = display[8*row_idx+7 : 8*row_idx].
REQ-014 IDLE SHALL move to BLANK with row_idx=0 on the cycle after pending first becomes full; on that move, pending is copied to display and pending is emptied.
REQ-015 BLANK SHALL last exactly BLANK_CYCLES cycles and then move to ON.
REQ-016 ON SHALL last exactly ROW_ON_CYCLES cycles and then move to BLANK.
- row_idx increments on this move, wrapping from 7 to 0.
REQ-017 The frame boundary SHALL be the ON(row 7) to BLANK(row 0) transition; the pending-to-display swap occurs only at this boundary, and only if pending is full.
- If pending is empty at the boundary, display is retained and the old frame repeats.
REQ-018 A transfer in the same cycle as the boundary SHALL NOT take part in that swap; the grid goes into pending and is shown at the next boundary.
REQ-019 frame_done SHALL pulse high during the last ON cycle of row 7.
REQ-020 Frame period SHALL be exactly 8*(BLANK_CYCLES+ROW_ON_CYCLES) cycles.
REQ-021 The display register SHALL NEVER change while in ON, so no row shows a mix of two generations.
REQ-022 Transitions SHALL NOT skip or repeat a row.
- Each frame drives rows 0..7 in order, each for exactly ROW_ON_CYCLES cycles.

Reset
REQ-023 While reset_n=0, the block SHALL hold these values asynchronously:
- state=IDLE, row_idx=0, pending empty, display=0
- row_sel_n=8'hFF, col_out=8'h00, grid_ready=1, frame_done=0
REQ-024 On reset assertion mid-frame, the block SHALL blank the display immediately (same-cycle asynchronous effect) and discard pending.
REQ-025 After reset_n rises, the block SHALL stay in IDLE until a transfer occurs.

Configuration
REQ-026 Macro GRID_SCAN_DIM_PWM_EN SHALL control PWM dimming.
- Defined: add input port brightness (3 bits). In ON, col_out is driven only when the low 3 bits of the ON-cycle counter are <= brightness, else 0. brightness=7 gives full on.
- Undefined: no brightness port; col_out is driven for all ON cycles.
- Defined with brightness=7: behaviour identical to undefined.

Verification (ROW_ON_CYCLES=4, BLANK_CYCLES=2)
REQ-027 Bench SHALL cover: reset release, then grid=64'h0000_0000_0000_00FF with valid for 1 cycle -> grid_ready=0 next cycle; 2 blank cycles; then row_sel_n=8'hFE and col_out=8'hFF for 4 cycles.
REQ-028 Bench SHALL cover: steady grid 64'h8040_2010_0804_0201 -> row r shows col_out=1<<r, frame_done pulses every 48 cycles.
REQ-029 Bench SHALL cover: a second grid offered mid-frame -> accepted, but display changes only at the row-0 BLANK after frame_done; grid_ready=0 until then.
REQ-030 Bench SHALL cover: valid asserted exactly on the boundary cycle -> old display repeats for one more frame; the new grid appears in the following frame.
REQ-031 Bench SHALL cover: reset_n pulled low during ON row 3 -> row_sel_n=8'hFF and col_out=0 in the same cycle, grid_ready=1, state IDLE.
REQ-032 Bench SHALL cover, with GRID_SCAN_DIM_PWM_EN defined: brightness=1 and all-ones grid -> col_out=8'hFF for ON cycles 0-1 and 8'h00 for ON cycles 2-3 of each row.
